// File: rtl/multicycle_alu.sv
// multicycle_alu
//   Clocked ALU with a start/busy/done handshake. Single-cycle operations
//   finish one cycle after accept. MULT uses an iterative shift-add
//   multiplier and DIV/MOD an iterative restoring divider, each taking
//   DATA_WIDTH cycles. Result and status flags are registered.
//
//   Build option: define MULTICYCLE_ALU_DIV_EN to build the restoring
//   divider. Without it DIV/MOD finish in one cycle with result 0 and
//   divByZero=1.
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high reset
//   start       request, accepted only while busy=0
//   opCode      operation, sampled at accept
//   inputData1  operand A, sampled at accept
//   inputData2  operand B, sampled at accept
//   outputData  registered result, held until the next completion
//   busy        iterative operation in progress
//   done        one-cycle completion pulse
//   zero        outputData==0, updated with done
//   divByZero   last DIV/MOD had B==0, updated with done
module multicycle_alu #(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [OPCODE_WIDTH-1:0] opCode,
  input  logic [DATA_WIDTH-1:0]   inputData1,
  input  logic [DATA_WIDTH-1:0]   inputData2,
  output logic [DATA_WIDTH-1:0]   outputData,
  output logic                    busy,
  output logic                    done,
  output logic                    zero,
  output logic                    divByZero
);

  localparam int CNT_WIDTH = $clog2(DATA_WIDTH);

  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_MULT = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_DIV  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_MOD  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_LSH  = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_RSH  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND  = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_OR   = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOT  = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_EQ   = OPCODE_WIDTH'(10);
  localparam logic [OPCODE_WIDTH-1:0] OP_NEQ  = OPCODE_WIDTH'(11);
  localparam logic [OPCODE_WIDTH-1:0] OP_LT   = OPCODE_WIDTH'(12);
  localparam logic [OPCODE_WIDTH-1:0] OP_LTE  = OPCODE_WIDTH'(13);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t                  state, state_next;
  logic                    accept;
  logic                    last_bit;
  logic [CNT_WIDTH-1:0]    bit_count;
  logic [DATA_WIDTH-1:0]   quick_result;
  logic                    quick_dbz;
  logic [DATA_WIDTH-1:0]   mul_acc, mul_cand, mul_plier, mul_sum;
`ifdef MULTICYCLE_ALU_DIV_EN
  logic [DATA_WIDTH-1:0]   div_rem, div_quo, div_sor;
  logic                    div_is_mod;
  logic [DATA_WIDTH:0]     div_shift, div_trial;
  logic                    div_fits;
  logic [DATA_WIDTH-1:0]   div_rem_next, div_quo_next;
`endif

  assign busy     = (state != IDLE);
  assign accept   = start && !busy;
  assign last_bit = (bit_count == CNT_WIDTH'(DATA_WIDTH - 1));

  // One shift-add step: add the multiplicand when the current multiplier bit is set.
  assign mul_sum = mul_plier[0] ? (mul_acc + mul_cand) : mul_acc;

`ifdef MULTICYCLE_ALU_DIV_EN
  // One restoring step: bring in the next dividend bit and subtract if it fits.
  // The partial remainder is always < divisor, so the shifted value fits in W+1 bits.
  assign div_shift    = {div_rem, div_quo[DATA_WIDTH-1]};
  assign div_trial    = div_shift - {1'b0, div_sor};
  assign div_fits     = !div_trial[DATA_WIDTH];
  assign div_rem_next = div_fits ? div_trial[DATA_WIDTH-1:0] : div_shift[DATA_WIDTH-1:0];
  assign div_quo_next = {div_quo[DATA_WIDTH-2:0], div_fits};
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (opCode == OP_MULT) state_next = MUL;
`ifdef MULTICYCLE_ALU_DIV_EN
          else if ((opCode == OP_DIV || opCode == OP_MOD) && inputData2 != '0)
            state_next = DIV;
`endif
        end
      end
      MUL:     if (last_bit) state_next = IDLE;
      DIV:     if (last_bit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result of every operation that completes at the accept edge.
  // Shifting by an amount >= DATA_WIDTH naturally yields 0 in SystemVerilog.
  always_comb begin
    quick_result = inputData1 + inputData2;
    quick_dbz    = 1'b0;
    case (opCode)
      OP_SUB: quick_result = inputData1 - inputData2;
`ifdef MULTICYCLE_ALU_DIV_EN
      OP_DIV: begin quick_result = '1;         quick_dbz = 1'b1; end
      OP_MOD: begin quick_result = inputData1; quick_dbz = 1'b1; end
`else
      OP_DIV: begin quick_result = '0;         quick_dbz = 1'b1; end
      OP_MOD: begin quick_result = '0;         quick_dbz = 1'b1; end
`endif
      OP_LSH: quick_result = inputData1 << inputData2;
      OP_RSH: quick_result = inputData1 >> inputData2;
      OP_AND: quick_result = DATA_WIDTH'((inputData1 != '0) && (inputData2 != '0));
      OP_OR:  quick_result = DATA_WIDTH'((inputData1 != '0) || (inputData2 != '0));
      OP_NOT: quick_result = DATA_WIDTH'(inputData1 == '0);
      OP_EQ:  quick_result = DATA_WIDTH'(inputData1 == inputData2);
      OP_NEQ: quick_result = DATA_WIDTH'(inputData1 != inputData2);
      OP_LT:  quick_result = DATA_WIDTH'($signed(inputData1) <  $signed(inputData2));
      OP_LTE: quick_result = DATA_WIDTH'($signed(inputData1) <= $signed(inputData2));
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      outputData <= '0;
      done       <= 1'b0;
      zero       <= 1'b0;
      divByZero  <= 1'b0;
      bit_count  <= '0;
      mul_acc    <= '0;
      mul_cand   <= '0;
      mul_plier  <= '0;
`ifdef MULTICYCLE_ALU_DIV_EN
      div_rem    <= '0;
      div_quo    <= '0;
      div_sor    <= '0;
      div_is_mod <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            bit_count  <= '0;
            mul_acc    <= '0;
            mul_cand   <= inputData1;
            mul_plier  <= inputData2;
`ifdef MULTICYCLE_ALU_DIV_EN
            div_rem    <= '0;
            div_quo    <= inputData1;
            div_sor    <= inputData2;
            div_is_mod <= (opCode == OP_MOD);
`endif
            // Staying in IDLE means this is a single-cycle operation.
            if (state_next == IDLE) begin
              outputData <= quick_result;
              zero       <= (quick_result == '0);
              divByZero  <= quick_dbz;
              done       <= 1'b1;
            end
          end
        end
        MUL: begin
          mul_acc   <= mul_sum;
          mul_cand  <= mul_cand << 1;
          mul_plier <= mul_plier >> 1;
          bit_count <= bit_count + CNT_WIDTH'(1);
          if (last_bit) begin
            outputData <= mul_sum;
            zero       <= (mul_sum == '0);
            divByZero  <= 1'b0;
            done       <= 1'b1;
          end
        end
`ifdef MULTICYCLE_ALU_DIV_EN
        DIV: begin
          div_rem   <= div_rem_next;
          div_quo   <= div_quo_next;
          bit_count <= bit_count + CNT_WIDTH'(1);
          if (last_bit) begin
            outputData <= div_is_mod ? div_rem_next : div_quo_next;
            zero       <= ((div_is_mod ? div_rem_next : div_quo_next) == '0);
            divByZero  <= 1'b0;
            done       <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu
//   Self-checking bench for multicycle_alu at default parameters. Runs a
//   table of directed vectors, hand-written handshake/reset sequences and a
//   randomized run checked against an arithmetic reference model.
//   Expectations for DIV/MOD follow MULTICYCLE_ALU_DIV_EN.
module tb_multicycle_alu;

  localparam int W = 32;
  localparam int TIMEOUT = 100;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [5:0]    opCode = '0;
  logic [W-1:0]  inputData1 = '0;
  logic [W-1:0]  inputData2 = '0;
  logic [W-1:0]  outputData;
  logic          busy, done, zero, divByZero;

  int checks = 0;
  int passes = 0;

  multicycle_alu dut (
    .clock(clock), .reset(reset), .start(start), .opCode(opCode),
    .inputData1(inputData1), .inputData2(inputData2),
    .outputData(outputData), .busy(busy), .done(done),
    .zero(zero), .divByZero(divByZero)
  );

  always #5 clock = ~clock;

  typedef struct {
    string        name;
    logic [5:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t vectors[$];

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Reference model: plain arithmetic on the operation definitions.
  function automatic void model(input logic [5:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] r,
                                output logic dbz, output int lat);
    longint unsigned prod;
    dbz = 1'b0;
    lat = 1;
    case (op)
      6'd1: r = a - b;
      6'd2: begin
        prod = longint'(a) * longint'(b);
        r = prod[W-1:0];
        lat = W + 1;
      end
      6'd3, 6'd4: begin
`ifdef MULTICYCLE_ALU_DIV_EN
        if (b == 0) begin
          dbz = 1'b1;
          r = (op == 6'd3) ? {W{1'b1}} : a;
        end else begin
          r = (op == 6'd3) ? a / b : a % b;
          lat = W + 1;
        end
`else
        dbz = 1'b1;
        r = '0;
`endif
      end
      6'd5:  r = (b >= W) ? '0 : a << b[4:0];
      6'd6:  r = (b >= W) ? '0 : a >> b[4:0];
      6'd7:  r = (a != 0 && b != 0) ? 1 : 0;
      6'd8:  r = (a != 0 || b != 0) ? 1 : 0;
      6'd9:  r = (a == 0) ? 1 : 0;
      6'd10: r = (a == b) ? 1 : 0;
      6'd11: r = (a != b) ? 1 : 0;
      6'd12: r = (int'(a) <  int'(b)) ? 1 : 0;
      6'd13: r = (int'(a) <= int'(b)) ? 1 : 0;
      default: r = a + b;
    endcase
  endfunction

  // Issues a request at the current negedge and waits for done. Optionally
  // pulses start again at wait cycle pulseAt with different operands.
  task automatic applyStimulus(input logic [5:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input int pulseAt,
                               output int lat, output int busyCycles);
    start = 1'b1;
    opCode = op;
    inputData1 = a;
    inputData2 = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    inputData1 = $urandom;
    inputData2 = $urandom;
    lat = 0;
    busyCycles = 0;
    do begin
      @(negedge clock);
      lat++;
      if (busy) busyCycles++;
      if (pulseAt != 0 && lat == pulseAt) begin
        start = 1'b1;
        opCode = 6'd0;
        inputData1 = 32'd1;
        inputData2 = 32'd1;
      end
      if (pulseAt != 0 && lat == pulseAt + 1) start = 1'b0;
    end while (!done && lat < TIMEOUT);
    start = 1'b0;
  endtask

  task automatic verifyTransaction(input string name, input logic [W-1:0] expR,
                                   input logic expDbz, input int expLat,
                                   input int lat, input int busyCycles);
    checkOutput({name, " result"}, outputData, expR);
    checkOutput({name, " zero"}, W'(zero), W'(expR == 0));
    checkOutput({name, " divByZero"}, W'(divByZero), W'(expDbz));
    checkOutput({name, " latency"}, W'(lat), W'(expLat));
    checkOutput({name, " busy cycles"}, W'(busyCycles), W'(expLat - 1));
  endtask

  function automatic void addVec(input string name, input logic [5:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] r, input logic dbz, input int lat);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b;
    v.result = r; v.dbz = dbz; v.lat = lat;
    vectors.push_back(v);
  endfunction

  initial begin
    int lat, busyCycles;
    logic [W-1:0] expR;
    logic expDbz;
    int expLat;
    logic [5:0] op;
    logic [W-1:0] a, b;

    addVec("mult 7*6",     6'd2,  32'd7,        32'd6,  32'd42,       1'b0, 33);
`ifdef MULTICYCLE_ALU_DIV_EN
    addVec("div 100/7",    6'd3,  32'd100,      32'd7,  32'd14,       1'b0, 33);
    addVec("mod 100%7",    6'd4,  32'd100,      32'd7,  32'd2,        1'b0, 33);
    addVec("div 5/0",      6'd3,  32'd5,        32'd0,  32'hFFFFFFFF, 1'b1, 1);
    addVec("mod 5%0",      6'd4,  32'd5,        32'd0,  32'd5,        1'b1, 1);
    addVec("div big",      6'd3,  32'hFFFFFFFF, 32'd1,  32'hFFFFFFFF, 1'b0, 33);
`else
    addVec("div 100/7",    6'd3,  32'd100,      32'd7,  32'd0,        1'b1, 1);
    addVec("mod 100%7",    6'd4,  32'd100,      32'd7,  32'd0,        1'b1, 1);
    addVec("div 5/0",      6'd3,  32'd5,        32'd0,  32'd0,        1'b1, 1);
`endif
    addVec("lt signed",    6'd12, 32'hFFFFFFFF, 32'd1,  32'd1,        1'b0, 1);
    addVec("lsh by 40",    6'd5,  32'd1,        32'd40, 32'd0,        1'b0, 1);
    addVec("op 63 as add", 6'd63, 32'd2,        32'd3,  32'd5,        1'b0, 1);
    addVec("sub wrap",     6'd1,  32'd3,        32'd5,  32'hFFFFFFFE, 1'b0, 1);
    addVec("rsh 31",       6'd6,  32'h80000000, 32'd31, 32'd1,        1'b0, 1);
    addVec("lsh 32",       6'd5,  32'hFFFFFFFF, 32'd32, 32'd0,        1'b0, 1);
    addVec("and 5,0",      6'd7,  32'd5,        32'd0,  32'd0,        1'b0, 1);
    addVec("or 0,8",       6'd8,  32'd0,        32'd8,  32'd1,        1'b0, 1);
    addVec("not 0",        6'd9,  32'd0,        32'd0,  32'd1,        1'b0, 1);
    addVec("lte equal",    6'd13, 32'h80000000, 32'h80000000, 32'd1,  1'b0, 1);
    addVec("neq",          6'd11, 32'd4,        32'd4,  32'd0,        1'b0, 1);
    addVec("mult wrap",    6'd2,  32'h10000,    32'h10000, 32'd0,     1'b0, 33);

    // Reset state
    repeat (3) @(negedge clock);
    checkOutput("reset outputData", outputData, '0);
    checkOutput("reset busy", W'(busy), '0);
    checkOutput("reset done", W'(done), '0);
    checkOutput("reset zero", W'(zero), '0);
    checkOutput("reset divByZero", W'(divByZero), '0);
    reset = 1'b0;

    // Directed table; each request is issued in the done cycle of the previous one.
    for (int i = 0; i < vectors.size(); i++) begin
      applyStimulus(vectors[i].op, vectors[i].a, vectors[i].b, 0, lat, busyCycles);
      verifyTransaction(vectors[i].name, vectors[i].result, vectors[i].dbz,
                        vectors[i].lat, lat, busyCycles);
    end

    // start pulsed mid-multiply must be ignored
    applyStimulus(6'd2, 32'd7, 32'd6, 5, lat, busyCycles);
    verifyTransaction("mult ignore start", 32'd42, 1'b0, 33, lat, busyCycles);

    // Reset mid-multiply after a stray start
    start = 1'b1; opCode = 6'd2; inputData1 = 32'd9; inputData2 = 32'd9;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (c == 3) begin
        start = 1'b1; opCode = 6'd0; inputData1 = 32'd100; inputData2 = 32'd200;
      end
      if (c == 4) start = 1'b0;
    end
    checkOutput("busy before reset", W'(busy), W'(1));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("abort outputData", outputData, '0);
    checkOutput("abort busy", W'(busy), '0);
    checkOutput("abort done", W'(done), '0);
    checkOutput("abort zero", W'(zero), '0);
    checkOutput("abort divByZero", W'(divByZero), '0);
    applyStimulus(6'd0, 32'd1, 32'd1, 0, lat, busyCycles);
    verifyTransaction("add after reset", 32'd2, 1'b0, 1, lat, busyCycles);

    // Randomized run against the reference model
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'(63) : 6'($urandom_range(0, 15));
      a = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
      case ($urandom_range(0, 3))
        0: b = 32'($urandom);
        1: b = 32'($urandom_range(0, 40));
        2: b = '0;
        default: b = a;
      endcase
      model(op, a, b, expR, expDbz, expLat);
      applyStimulus(op, a, b, 0, lat, busyCycles);
      verifyTransaction($sformatf("rand%0d op%0d", n, op), expR, expDbz, expLat,
                        lat, busyCycles);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised, clocked successor to the combinational ALU. It keeps the same 14-operation opcode map and result semantics, and adds:
- a start/busy/done handshake;
- iterative shift-add multiply and restoring divide that take one cycle per bit instead of a single-cycle array;
- registered status flags.

It sits between the register-file read stage and write-back, and holds the pipeline while `busy` is high.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width (≥ 4)
- OPCODE_WIDTH, 6, opcode width

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when `busy`=0
- opCode  input  OPCODE_WIDTH  operation, sampled at accept
- inputData1  input  DATA_WIDTH  operand A, sampled at accept
- inputData2  input  DATA_WIDTH  operand B, sampled at accept
- outputData  output  DATA_WIDTH  registered result, held until the next completion
- busy  output  1  an iterative operation is in progress
- done  output  1  one-cycle pulse; `outputData` and the flags are valid
- zero  output  1  `outputData`==0, updated with `done`
- divByZero  output  1  last DIV/MOD had `inputData2`==0, updated with `done`

## Operation
Opcodes:
- 0 ADD, 1 SUB: modulo 2^DATA_WIDTH.
- 2 MULT: low DATA_WIDTH bits of the unsigned product.
- 3 DIV, 4 MOD: unsigned quotient and remainder.
- 5 LSH, 6 RSH: logical shifts by the full value of B; a shift amount ≥ DATA_WIDTH gives 0.
- 7 AND, 8 OR, 9 NOT: logical, not bitwise. Result is 0 or 1, zero-extended.
- 10 EQ, 11 NEQ, 12 LT, 13 LTE: signed two's-complement compare. Result is 0 or 1.
- Any other opcode: executes as ADD.

Handshake and execution:
- The request is accepted on a clock edge where `start`=1 and `busy`=0. Operands and opcode are latched at that edge.
- `start` while `busy`=1 is ignored.
- Operand changes after the accept have no effect.

State machine (IDLE, MUL, DIV):
- IDLE: on accept of MULT, go to MUL. On accept of DIV/MOD with B≠0, go to DIV. Any other op is computed at the accept edge and `done` asserts the next cycle; the state stays IDLE.
- MUL: shift-add, one multiplier bit per cycle, DATA_WIDTH iterations. A bit counter runs 0..DATA_WIDTH-1. On the last iteration, write the result, pulse `done`, and return to IDLE.
- DIV: restoring divide, one quotient bit per cycle, DATA_WIDTH iterations. At completion, write the quotient (DIV) or remainder (MOD), pulse `done`, and return to IDLE.
- DIV/MOD with B=0: single-cycle. DIV gives all-ones, MOD gives A, and `divByZero`=1. For every other completion, `divByZero`=0.
- `busy`=1 exactly while in MUL or DIV.
- The `done` cycle has `busy`=0, so a new `start` in that cycle is accepted (back-to-back).

Reset:
- Reset at any time, including mid-iteration, aborts the operation.
- Next state is IDLE.
- `outputData`=0, `busy`=0, `done`=0, `zero`=0, `divByZero`=0.

## Timing
- Accept at edge N; single-cycle op: `done`=1 and result valid in cycle N+1 (latency 1).
- MULT and DIV/MOD (B≠0): `busy`=1 for cycles N+1..N+DATA_WIDTH; `done`=1 in cycle N+DATA_WIDTH+1 (latency DATA_WIDTH+1, i.e. 33 at default).
- `done` is never high for two consecutive cycles unless a single-cycle op was accepted in the preceding `done` cycle.
- No combinational path from inputs to outputs.

## Configuration
- MULTICYCLE_ALU_DIV_EN defined: the DIV state and the restoring divider are built as described above.
- Not defined: no divider hardware. DIV and MOD complete in one cycle with `outputData`=0 and `divByZero`=1 regardless of operands. All other opcodes are unchanged.

## Test plan
Defaults (DATA_WIDTH=32), MULTICYCLE_ALU_DIV_EN defined:
- Reset, then MULT A=7, B=6 → `busy` high 32 cycles; `done` 33 cycles after accept; `outputData`=42, `zero`=0.
- DIV A=100, B=7 → 14; then MOD with the same operands issued in the `done` cycle → 2. Both have latency 33.
- DIV A=5, B=0 → latency 1, `outputData`=0xFFFFFFFF, `divByZero`=1. Then MOD A=5, B=0 → 5, `divByZero`=1.
- LT A=0xFFFFFFFF, B=1 → 1 (signed). LSH A=1, B=40 → 0, `zero`=1. Opcode 63, A=2, B=3 → 5.
- MULT accepted, `start` pulsed again mid-iteration with other operands (ignored), reset asserted at iteration 10 → next cycle all outputs 0, `busy`=0. A new ADD 1+1 then yields 2 at latency 1.
- Macro undefined: DIV A=100, B=7 → latency 1, `outputData`=0, `divByZero`=1.
